// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard bundle: decode-side operand/destination info in, stall/forward/MDU status out.
// The master side belongs to the decode stage and the slave side to hazard_scoreboard.
interface hazard_scoreboard_if #(
   parameter int TNEW_W = 4
);
   logic [4:0]        i_D_Rs;
   logic [4:0]        i_D_Rt;
   logic [TNEW_W-1:0] i_D_TuseRs;
   logic [TNEW_W-1:0] i_D_TuseRt;
   logic [4:0]        i_D_WAddr;
   logic [TNEW_W-1:0] i_D_Tnew;
   logic [1:0]        i_D_MDU_Op;
   logic              i_Flush;
   logic              o_Stall;
   logic [2:0]        o_FwdRs;
   logic [2:0]        o_FwdRt;
   logic              o_MDU_Busy;

   modport master (
      output i_D_Rs, i_D_Rt, i_D_TuseRs, i_D_TuseRt, i_D_WAddr, i_D_Tnew, i_D_MDU_Op, i_Flush,
      input  o_Stall, o_FwdRs, o_FwdRt, o_MDU_Busy
   );

   modport slave (
      input  i_D_Rs, i_D_Rt, i_D_TuseRs, i_D_TuseRt, i_D_WAddr, i_D_Tnew, i_D_MDU_Op, i_Flush,
      output o_Stall, o_FwdRs, o_FwdRt, o_MDU_Busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard of in-flight destinations/Tnew after D plus an MDU busy counter, giving stall and forward selects.
// Define HAZARD_SCOREBOARD_FWD_EN for forwarding; otherwise the pipeline is fully interlocked.
module hazard_scoreboard #(
   parameter int DEPTH    = 3,
   parameter int TNEW_W   = 4,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input logic                clk,
   input logic                reset_n,
   hazard_scoreboard_if.slave dec
);

   localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [TNEW_W-1:0] TNEW_ONE = TNEW_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   logic [4:0]        ent_waddr [1:DEPTH];
   logic [TNEW_W-1:0] ent_tnew  [1:DEPTH];
   logic [1:0]        ent_mdu   [1:DEPTH];
   logic [CNT_W-1:0]  cnt;

   logic       data_stall;
   logic       mdu_stall;
   logic       stall;
   logic       rs_hit;
   logic       rt_hit;
   logic [2:0] fwd_rs;
   logic [2:0] fwd_rt;

   // Scoreboard shift register; flush bubbles everything, a stall bubbles only the E entry.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 1; k <= DEPTH; k++) begin
            ent_waddr[k] <= '0;
            ent_tnew[k]  <= '0;
            ent_mdu[k]   <= '0;
         end
      end else if (dec.i_Flush) begin
         for (int k = 1; k <= DEPTH; k++) begin
            ent_waddr[k] <= '0;
            ent_tnew[k]  <= '0;
            ent_mdu[k]   <= '0;
         end
      end else begin
         if (stall) begin
            ent_waddr[1] <= '0;
            ent_tnew[1]  <= '0;
            ent_mdu[1]   <= '0;
         end else begin
            ent_waddr[1] <= dec.i_D_WAddr;
            ent_tnew[1]  <= dec.i_D_Tnew;
            ent_mdu[1]   <= dec.i_D_MDU_Op;
         end
         for (int k = 2; k <= DEPTH; k++) begin
            ent_waddr[k] <= ent_waddr[k-1];
            ent_tnew[k]  <= (ent_tnew[k-1] != '0) ? ent_tnew[k-1] - TNEW_ONE : '0;
            ent_mdu[k]   <= ent_mdu[k-1];
         end
      end
   end

   // MDU busy counter starts when a mult/div leaves E; a flush kills that start but not a running count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!dec.i_Flush && ent_mdu[1] == 2'd2) begin
         cnt <= CNT_W'(MULT_CYC);
      end else if (!dec.i_Flush && ent_mdu[1] == 2'd3) begin
         cnt <= CNT_W'(DIV_CYC);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_ONE;
      end
   end

   // Scan oldest to youngest so the youngest matching producer ends up as the forward source.
   always_comb begin
      data_stall = 1'b0;
      fwd_rs     = 3'd0;
      fwd_rt     = 3'd0;
      rs_hit     = 1'b0;
      rt_hit     = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         rs_hit = (dec.i_D_Rs == ent_waddr[k]) && (ent_waddr[k] != 5'd0);
         rt_hit = (dec.i_D_Rt == ent_waddr[k]) && (ent_waddr[k] != 5'd0);
`ifdef HAZARD_SCOREBOARD_FWD_EN
         if (rs_hit) fwd_rs = 3'(k);
         if (rt_hit) fwd_rt = 3'(k);
         if (rs_hit && (dec.i_D_TuseRs < ent_tnew[k])) data_stall = 1'b1;
         if (rt_hit && (dec.i_D_TuseRt < ent_tnew[k])) data_stall = 1'b1;
`else
         if (rs_hit && (dec.i_D_TuseRs != '1) && ((ent_tnew[k] != '0) || (k < DEPTH)))
            data_stall = 1'b1;
         if (rt_hit && (dec.i_D_TuseRt != '1) && ((ent_tnew[k] != '0) || (k < DEPTH)))
            data_stall = 1'b1;
`endif
      end
      mdu_stall = (dec.i_D_MDU_Op != 2'd0) && ((cnt != '0) || ent_mdu[1][1]);
      stall     = data_stall || mdu_stall;
   end

   assign dec.o_Stall    = stall;
   assign dec.o_FwdRs    = fwd_rs;
   assign dec.o_FwdRt    = fwd_rt;
   assign dec.o_MDU_Busy = (cnt != '0);

endmodule
